// File: rtl/seek_f_mc.sv
// seek_f_mc: two-stage multichannel scale-and-saturate pipeline.
// Stage 1 folds the top bit of the raw word in as a rounding correction and
// looks up the channel's shift. Stage 2 shifts, saturates to OW bits and
// presents the beat. A single advance signal moves both stages, so
// backpressure from out_ready stalls the whole pipe without dropping beats.
module seek_f_mc #(
  parameter int unsigned DW  = 14,
  parameter int unsigned OW  = 17,
  parameter int unsigned NCH = 4,
  parameter int unsigned SH0 = 3,
  localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] in_ch,
  input  logic [DW-1:0] in_e,
  input  logic          cfg_we,
  input  logic [CW-1:0] cfg_ch,
  input  logic [4:0]    cfg_shift,
  input  logic          sat_clr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_ch,
  output logic [OW-1:0] out_f,
  output logic          out_sat,
  output logic [NCH-1:0] sat_flags
);

  // Shifted value is wide enough that no shift amount can lose bits.
  localparam int unsigned VW = DW + 31;
  localparam logic [4:0] ShRst = 5'(SH0);

  logic adv;

  // Per-channel shift table.
  logic [4:0] shift_tbl [NCH];

  // Stage 1 registers.
  logic          s1_valid;
  logic [DW-1:0] s1_r;
  logic [CW-1:0] s1_ch;
  logic [4:0]    s1_shift;
  logic          s1_known;

  // Combinational helpers.
  logic [4:0]     in_shift;
  logic           in_known;
  logic [DW-1:0]  in_r;
  logic [VW-1:0]  s2_v;
  logic           s2_over;
  logic [OW-1:0]  s2_f;
  logic           out_known;
  logic [NCH-1:0] flags_d;

  // Pipeline advances whenever the output slot is empty or being drained.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Shift table: writes to channels outside the table are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        shift_tbl[c] <= ShRst;
      end
    end else if (cfg_we) begin
      for (int c = 0; c < NCH; c++) begin
        if (cfg_ch == CW'(c)) begin
          shift_tbl[c] <= cfg_shift;
        end
      end
    end
  end

  // Shift lookup for the incoming beat; unknown channels get shift 0.
  always_comb begin
    in_shift = '0;
    in_known = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      if (in_ch == CW'(c)) begin
        in_shift = shift_tbl[c];
        in_known = 1'b1;
      end
    end
  end

  // Correction: add the top bit to the remaining bits, keeping the carry.
  always_comb begin
    in_r = {1'b0, in_e[DW-2:0]} + {{(DW-1){1'b0}}, in_e[DW-1]};
  end

  // Stage 1 register: valid follows in_valid so bubbles travel as bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_r     <= '0;
      s1_ch    <= '0;
      s1_shift <= '0;
      s1_known <= 1'b0;
    end else if (adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_r     <= in_r;
        s1_ch    <= in_ch;
        s1_shift <= in_shift;
        s1_known <= in_known;
      end
    end
  end

  // Stage 2 shift and saturate.
  always_comb begin
    s2_v    = {{(VW-DW){1'b0}}, s1_r} << s1_shift;
    s2_over = |s2_v[VW-1:OW];
    s2_f    = s2_over ? '1 : s2_v[OW-1:0];
  end

  // Output register: payload only changes when a real beat moves in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_f     <= '0;
      out_ch    <= '0;
      out_sat   <= 1'b0;
      out_known <= 1'b0;
    end else if (adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_f     <= s2_f;
        out_ch    <= s1_ch;
        out_sat   <= s2_over;
        out_known <= s1_known;
      end
    end
  end

  // Sticky flags: clear first, then a saturating transfer sets, so set wins.
  always_comb begin
    flags_d = sat_clr ? '0 : sat_flags;
    if (out_valid && out_ready && out_sat && out_known) begin
      for (int c = 0; c < NCH; c++) begin
        if (out_ch == CW'(c)) begin
          flags_d[c] = 1'b1;
        end
      end
    end
  end

  // Sticky flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_flags <= '0;
    end else begin
      sat_flags <= flags_d;
    end
  end

endmodule
